// File: rtl/operand_select.sv
// operand_select: registered operand selector with same-cycle writeback bypass and a 2-entry output queue
module operand_select #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REGS*WIDTH-1:0] regs_flat,
  input  logic [WIDTH-1:0]          immediate,
  input  logic [WIDTH-1:0]          def_val,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      wb_en,
  input  logic [SEL_W-1:0]          wb_addr,
  input  logic [WIDTH-1:0]          wb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_err
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state;
  logic [WIDTH:0] head, tail, entry;
  logic [WIDTH-1:0] reg_val;
  logic push, pop;
  // decode the requested source into an {err, data} entry, writeback taking priority for register selects
  always_comb begin
    reg_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (sel == SEL_W'(i)) reg_val = regs_flat[i*WIDTH +: WIDTH];
    entry = sel < SEL_W'(NUM_REGS) ? {1'b0, (wb_en && wb_addr == sel) ? wb_data : reg_val} :
            sel == SEL_W'(NUM_REGS) ? {1'b0, immediate} :
            sel == SEL_W'(NUM_REGS + 1) ? {1'b0, def_val} : {1'b1, {WIDTH{1'b0}}};
  end
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign {out_err, out_data} = head;
  // queue occupancy FSM; head is cleared whenever the queue drains so outputs idle at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      unique case (state)
        EMPTY: if (push) begin
          state <= ONE;
          head  <= entry;
        end
        ONE: if (push && !pop) begin
          state <= FULL;
          tail  <= entry;
        end else if (push) begin
          head <= entry;
        end else if (pop) begin
          state <= EMPTY;
          head  <= '0;
        end
        FULL: if (pop) begin
          state <= ONE;
          head  <= tail;
        end
        default: begin
          state <= EMPTY;
          head  <= '0;
        end
      endcase
    end
  end
endmodule

// File: doc/operand_select.md
# operand_select

Parametrised, registered operand selector for the bitty datapath. Each accepted request picks one source from a register-file snapshot, the instruction immediate, or a default value. Register sources can be bypassed from the same-cycle writeback, and the result is buffered in a 2-entry output queue with a valid/ready handshake. It sits between the register file and the ALU operand inputs, replacing the purely combinational selection stage.

## Interface
Parameters:
- WIDTH, 16: data width of every source and of the result.
- NUM_REGS, 8: number of register sources, at least 2.
- SEL_W, 4: select width; must satisfy 2^SEL_W >= NUM_REGS+2.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high; sampled on the rising edge of clk.
- regs_flat, input, NUM_REGS*WIDTH: register snapshot; reg i occupies bits [i*WIDTH +: WIDTH].
- immediate, input, WIDTH: immediate source.
- def_val, input, WIDTH: default source.
- sel, input, SEL_W: source select, qualified by in_valid.
- in_valid, input, 1: request present.
- in_ready, output, 1: request can be accepted this cycle.
- wb_en, input, 1: writeback in progress this cycle.
- wb_addr, input, SEL_W: writeback register index.
- wb_data, input, WIDTH: writeback data.
- out_valid, output, 1: head entry is valid.
- out_ready, input, 1: consumer takes the head entry this cycle.
- out_data, output, WIDTH: head entry data.
- out_err, output, 1: head entry was produced from an illegal select.

## Operation
- Request accepted ("push") when in_valid && in_ready at a clock edge.
- Source decode at the accepting edge:
  - sel < NUM_REGS: reg[sel].
  - sel == NUM_REGS: immediate.
  - sel == NUM_REGS+1: def_val.
  - Any other value: data 0, err = 1.
- Bypass: if sel < NUM_REGS && wb_en && wb_addr == sel, data = wb_data. The register value is ignored. wb_en has no effect on immediate, def_val, or illegal selects.
- Buffer: 2-entry FIFO of {data, err}. States EMPTY (count 0), ONE (count 1), FULL (count 2).
- in_ready = (count != 2). It is a combinational function of state only and does not depend on out_ready, so there is no combinational path from out_ready to in_ready.
- Pop when out_valid && out_ready.
- State transitions:
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push and pop together → ONE, with the new entry becoming the head.
  - FULL: pop → ONE. Push is impossible because in_ready = 0.
- out_valid = (count != 0).
- out_data and out_err come from the head entry. When count == 0 they hold 0.
- Order is strictly FIFO; no entry is dropped or duplicated.
- Entry data is frozen at the push edge. Later changes to regs_flat or writeback do not alter stored entries.
- in_valid while in_ready = 0: request is not taken. The upstream block must hold it.

## Timing
- Latency: push at edge N → out_valid = 1 after edge N, provided the buffer was EMPTY or the head was popped at N.
- Throughput: 1 request per cycle when out_ready is held high.
- Reset (synchronous, any state, including mid-stream):
  - After the edge: count = 0, out_valid = 0, out_data = 0, out_err = 0, in_ready = 1.
  - A push or pop presented on the reset edge is discarded.
- Clock gating or enables: none. Every edge evaluates push, pop and reset.

## Test plan
- Basic select: regs r0..r7 = 16'h1000+i, immediate = 16'hBEEF, def_val = 16'h00AA, out_ready = 1. Push sel = 3, 8, 9 on consecutive cycles → out_data 16'h1003, 16'hBEEF, 16'h00AA on the following cycles, each with out_valid = 1 and out_err = 0.
- Illegal select: push sel = 4'hF → out_data = 0, out_err = 1 one cycle later. Next push of sel = 0 → 16'h1000, out_err = 0.
- Bypass: sel = 5, wb_en = 1, wb_addr = 5, wb_data = 16'h5A5A → out_data = 16'h5A5A. Repeat with wb_addr = 4 → 16'h1005. Repeat with sel = 8, wb_addr = 8 → 16'hBEEF.
- Backpressure: out_ready = 0, push sel = 1, 2 → in_ready falls to 0 after the second push, and a third request (sel = 3) is held. Raise out_ready → 16'h1001, 16'h1002, 16'h1003 appear in order with no loss.
- Simultaneous push/pop in ONE state: count stays 1 and the head advances to the new entry. Change regs_flat after the push and check that the stored data is unchanged.
- Reset mid-stream: with the buffer FULL, assert reset for one cycle while in_valid = 1 → out_valid = 0, out_data = 0, out_err = 0, in_ready = 1. No stale entry appears afterwards.
